// File: rtl/vram_text_if.sv
// Bus bundle for vram_text: CPU read/write port A, display read port B,
// and the clear-engine request/status signals.
interface vram_text_if #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 11
);
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic [DATA_W-1:0] douta;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] doutb;
  logic              clr_start;
  logic [DATA_W-1:0] fill_val;
  logic              busy;
  logic              done;

  modport master (
    output wea, addra, dina, addrb, clr_start, fill_val,
    input  douta, doutb, busy, done
  );

  modport slave (
    input  wea, addra, dina, addrb, clr_start, fill_val,
    output douta, doutb, busy, done
  );
endinterface

// File: rtl/vram_text.sv
// Dual-port text-mode video RAM with a hardware fill engine.
// Define VRAM_CLEAR_EN to build the clear engine; otherwise busy/done are tied low.
module vram_text #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2000
) (
  input  logic        clka,
  input  logic        rst,
  vram_text_if.slave  bus
);

  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic a_in_range;
  logic b_in_range;
  logic wr_a;

  logic              clr_active;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_data;

  assign a_in_range = ({1'b0, bus.addra} <= LAST);
  assign b_in_range = ({1'b0, bus.addrb} <= LAST);
  assign wr_a       = bus.wea && a_in_range && !clr_active;

`ifdef VRAM_CLEAR_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] fill_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      fill_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr_start) begin
            fill_q <= bus.fill_val;
            cnt    <= '0;
            state  <= CLEAR;
          end
        end
        CLEAR: begin
          // Stop on the last cell so cnt never leaves 0..DEPTH-1.
          if ({1'b0, cnt} == LAST) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign clr_active = (state == CLEAR);
  assign clr_addr   = cnt;
  assign clr_data   = fill_q;
  assign bus.busy   = (state == CLEAR);
  assign bus.done   = (state == DONE);
`else
  logic unused_clr;

  assign clr_active = 1'b0;
  assign clr_addr   = '0;
  assign clr_data   = '0;
  assign bus.busy   = 1'b0;
  assign bus.done   = 1'b0;
  assign unused_clr = ^{bus.clr_start, bus.fill_val};
`endif

  // NOTE: the array has no reset so it maps onto block RAM; only the output
  // registers are cleared by rst.
  always_ff @(posedge clka) begin
    if (clr_active) begin
      mem[clr_addr] <= clr_data;
    end else if (wr_a) begin
      mem[bus.addra] <= bus.dina;
    end
  end

  // Both read registers sample the array before this edge's write lands,
  // which gives read-first behaviour on A and old data on B.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      bus.douta <= '0;
      bus.doutb <= '0;
    end else begin
      bus.douta <= a_in_range ? mem[bus.addra] : '0;
      bus.doutb <= b_in_range ? mem[bus.addrb] : '0;
    end
  end

endmodule

// File: doc/vram_text.md
# vram_text

Parametrised dual-port text-mode video RAM. It is the successor to the single-word VRAM stub. The CPU side gets a synchronous read/write port (A). The VGA character generator gets an independent read-only port (B). A hardware clear engine fills every cell with a programmable word, so the CPU does not have to loop over the screen. Each cell holds `{attr[2:0], char[15:0]}` at the default width.

## Interface
- `DATA_W`, 19, cell width (attribute + character code)
- `ADDR_W`, 11, address width of both ports
- `DEPTH`, 2000, number of implemented cells (80x25); legal range 1..2**ADDR_W
- `clka`  in  1  the only clock; all state changes on its rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `wea`  in  1  port A write enable
- `addra`  in  ADDR_W  port A address
- `dina`  in  DATA_W  port A write data
- `douta`  out  DATA_W  port A registered read data
- `addrb`  in  ADDR_W  port B (display) address
- `doutb`  out  DATA_W  port B registered read data
- `clr_start`  in  1  one-cycle request to fill the whole memory
- `fill_val`  in  DATA_W  fill word, latched together with `clr_start`
- `busy`  out  1  clear engine is writing
- `done`  out  1  one-cycle pulse when a clear completes

## Operation
- **Memory array.** `DEPTH` words. The array is not affected by `rst`; its contents after power-up are undefined.
- **Port A write.** With `wea`=1, `addra` < `DEPTH` and the engine not in CLEAR, `dina` is written at the edge.
  - `addra` >= `DEPTH`: the write is dropped.
  - Any write while in CLEAR is dropped, with no error flag.
- **Port A read.** Happens every cycle regardless of `wea`; `douta` follows the read-first rules under Timing.
  - `addra` >= `DEPTH` reads 0.
- **Port B read.** Happens every cycle.
  - `addrb` >= `DEPTH` reads 0.
  - Port B is never blocked, including during CLEAR.
- **Clear engine states.** IDLE, CLEAR, DONE. Reset state is IDLE.
  - **IDLE.** `clr_start`=1 latches `fill_val` into `fill_q`, clears the counter `cnt` (ADDR_W bits), and moves to CLEAR.
  - **CLEAR.** Each cycle writes `fill_q` to `mem[cnt]` and increments `cnt`. The write at `cnt`=`DEPTH`-1 moves the state to DONE.
  - **DONE.** Lasts one cycle, then returns to IDLE.
  - `clr_start` is ignored in CLEAR and DONE; it is neither queued nor restarted.
- **Outputs.** `busy` = (state==CLEAR). `done` = (state==DONE). Both are decoded directly from the state register, with no extra register stage.
- **Reset mid-clear.** State returns to IDLE and the counter to 0. Cells already written keep `fill_val`; the remaining cells keep their old data.

## Timing
- **Reset values.** `douta`=0, `doutb`=0, `busy`=0, `done`=0, `cnt`=0, `fill_q`=0.
- **Read latency.** 1 cycle on both ports. An address presented before edge k is valid on the output after edge k.
- **Read-during-write, port A same address.** Read-first: `douta` shows the old contents; new data is visible one cycle later.
- **Port B read of the address being written** (by port A or by the clear engine). `doutb` shows the old contents.
- **Clear sequence.** `clr_start` sampled at edge k.
  - `busy`=1 from after edge k.
  - Writes to addresses 0..`DEPTH`-1 happen at edges k+1..k+`DEPTH`.
  - `busy` drops and `done`=1 after edge k+`DEPTH`.
  - `done` returns to 0 after edge k+`DEPTH`+1.
  - `busy` is high for exactly `DEPTH` cycles.
- **Simultaneous `clr_start` and `wea` in IDLE.** The port A write is performed at edge k, then overwritten later by the fill.
- **Port A write during DONE.** Accepted.
- **`DEPTH`=1.** CLEAR lasts one cycle.
- **Counter range.** `cnt` never exceeds `DEPTH`-1, so it needs no wrap logic.

## Configuration
- **`VRAM_CLEAR_EN` defined.** The clear engine described above is present.
- **`VRAM_CLEAR_EN` not defined.**
  - No state register, counter or `fill_q` is built.
  - `busy` and `done` are tied to 0.
  - `clr_start` and `fill_val` are ignored.
  - Port A writes are never blocked.
  - The port list is unchanged.

## Test plan
- **Reset.** Assert `rst` asynchronously mid-cycle -> `douta`=`doutb`=0, `busy`=`done`=0 immediately, with no clock edge needed.
- **Write/read with read-first.**
  - Stimulus: write `0x30061` to addr 5 with `wea`=1 while `addra`=5; next cycle read addr 5 on A and B.
  - Required: `douta` shows the old value after the write edge and `0x30061` one cycle later; `doutb`=`0x30061` one cycle after `addrb`=5.
- **Out of range.** Write `0x7FFFF` at addr 2000 (default `DEPTH`) -> reading addr 2000 returns 0, and addr 2000 mod 2048 aliasing does not corrupt addr 0.
- **Full clear.**
  - Stimulus: `clr_start` with `fill_val`=`0x60020`.
  - Required: `busy` high exactly 2000 cycles, then `done` high 1 cycle; every address 0..1999 reads `0x60020` on port B.
  - Additionally: a port A write of `0x11111` to addr 10 issued mid-clear is dropped, so addr 10 reads `0x60020`.
- **Ignored restart and reset abort.**
  - Stimulus: `clr_start` again at clear cycle 100 -> ignored, and `busy` still falls at cycle 2000.
  - Stimulus: a second clear with `fill_val`=`0x00000`, with `rst` asserted after 50 writes.
  - Required: `busy`=0 immediately; addrs 0..49 read 0 and addr 50 keeps `0x60020`.
- **Build without `VRAM_CLEAR_EN`.** Pulse `clr_start` -> `busy`/`done` stay 0 and memory is unchanged.
